// File: rtl/loop_iter_unit_if.sv
// Index-tuple stream from loop_iter_unit to the address-generation stage.
// The unit drives the tuple, valid and last flags; the consumer drives ready.
interface loop_iter_unit_if #(
    parameter int unsigned ADDRESS_WIDTH = 4
);
    logic [8*ADDRESS_WIDTH-1:0] idx_out;
    logic                       idx_valid;
    logic                       idx_ready;
    logic                       idx_last;

    modport master (
        output idx_out,
        output idx_valid,
        output idx_last,
        input  idx_ready
    );

    modport slave (
        input  idx_out,
        input  idx_valid,
        input  idx_last,
        output idx_ready
    );
endinterface

// File: rtl/loop_iter_unit.sv
// Fetches a packed loop-bound word from program memory, then walks the nested loop
// space in odometer order, emitting one index tuple per valid/ready handshake.
module loop_iter_unit #(
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned FETCH_WAIT    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 prog_addr,
    output logic                       busy,
    output logic [7:0]                 read_prog_addr,
    output logic                       reset_read,
    input  logic [8*ADDRESS_WIDTH-1:0] loop_read_data,
    output logic                       done,
    loop_iter_unit_if.master           idx
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRst     = 3'd1;
    localparam logic [2:0] StWait    = 3'd2;
    localparam logic [2:0] StCapture = 3'd3;
    localparam logic [2:0] StRun     = 3'd4;
    localparam logic [2:0] StFin     = 3'd5;

    localparam logic [7:0] WaitLast = 8'(FETCH_WAIT - 1);

    logic [2:0]                    state_q, state_d;
    logic [7:0]                    addr_q, addr_d;
    logic [7:0]                    wait_q, wait_d;
    logic [ADDRESS_WIDTH-1:0][7:0] bound_q, bound_d;
    logic [ADDRESS_WIDTH-1:0][7:0] cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0][7:0] cnt_inc;
    logic [ADDRESS_WIDTH-1:0]      at_max;
    logic                          any_zero;
    logic                          carry;
    logic                          last;
    logic                          handshake;

    // Odometer increment: dim 0 steps, each wrapping dim carries into the next.
    always_comb begin
        any_zero = 1'b0;
        carry    = 1'b1;
        at_max   = '0;
        cnt_inc  = cnt_q;
        for (int i = 0; i < ADDRESS_WIDTH; i++) begin
            at_max[i] = (cnt_q[i] == bound_q[i] - 8'd1);
            if (loop_read_data[8*i +: 8] == 8'd0) begin
                any_zero = 1'b1;
            end
            if (carry) begin
                if (at_max[i]) begin
                    cnt_inc[i] = 8'd0;
                end else begin
                    cnt_inc[i] = cnt_q[i] + 8'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    assign last      = (state_q == StRun) && (&at_max);
    assign handshake = (state_q == StRun) && idx.idx_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        bound_d = bound_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = prog_addr;
                    state_d = StRst;
                end
            end
            StRst: begin
                wait_d  = 8'd0;
                state_d = StWait;
            end
            StWait: begin
                if (wait_q == WaitLast) begin
                    state_d = StCapture;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StCapture: begin
                // A zero trip count in any dimension means the program has no tuples.
                if (any_zero) begin
                    state_d = StFin;
                end else begin
                    bound_d = loop_read_data;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (handshake) begin
                    if (last) begin
                        state_d = StFin;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= 8'd0;
            wait_q  <= 8'd0;
            bound_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            bound_q <= bound_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign reset_read     = (state_q == StRst);
    assign done           = (state_q == StFin);
    assign read_prog_addr = addr_q;
    assign idx.idx_valid  = (state_q == StRun);
    assign idx.idx_out    = cnt_q;
    assign idx.idx_last   = last;

endmodule

// File: tb/tb_loop_iter_unit.sv
// Directed and randomized bench for loop_iter_unit with a small program-memory model
// and an arithmetic reference for the expected tuple sequence.
module tb_loop_iter_unit;

    localparam int unsigned AW = 4;
    localparam int unsigned FW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  prog_addr;
    logic        busy;
    logic [7:0]  read_prog_addr;
    logic        reset_read;
    logic [31:0] loop_read_data;
    logic        done;

    loop_iter_unit_if #(.ADDRESS_WIDTH(AW)) idx_if ();

    loop_iter_unit #(
        .ADDRESS_WIDTH(AW),
        .FETCH_WAIT(FW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .prog_addr(prog_addr),
        .busy(busy),
        .read_prog_addr(read_prog_addr),
        .reset_read(reset_read),
        .loop_read_data(loop_read_data),
        .done(done),
        .idx(idx_if)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int fetches  = 0;
    int mem_wait = 0;
    int checks   = 0;
    int errors   = 0;

    // Memory returns garbage until FETCH_WAIT edges after the read-reset edge.
    always @(posedge clk) begin
        if (reset_read) begin
            fetches        <= fetches + 1;
            mem_wait       <= FW;
            loop_read_data <= 32'hDEADBEEF;
        end else if (mem_wait == 1) begin
            loop_read_data <= mem[read_prog_addr];
            mem_wait       <= 0;
        end else if (mem_wait > 1) begin
            mem_wait <= mem_wait - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tuple k of the nest: field i is (k / product of inner bounds) mod bound_i.
    function automatic logic [31:0] exp_tuple(input logic [31:0] w, input int k);
        int div;
        int b;
        logic [31:0] t;
        div = 1;
        t   = '0;
        for (int i = 0; i < 4; i++) begin
            b = int'(w[8*i +: 8]);
            t[8*i +: 8] = 8'((k / div) % b);
            div = div * b;
        end
        return t;
    endfunction

    function automatic logic next_ready(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((c % 2) == 1);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_prog(input logic [7:0] addr, input int mode, input bit mid_start,
                            input bit hold, input bit abort);
        logic [31:0] w;
        logic [31:0] prev_idx;
        int total, base, c, n, first_valid, last_hs, done_c, busy_cnt;
        bit prev_stall, seen;
        w = mem[addr];
        total = 1;
        for (int i = 0; i < 4; i++) total = total * int'(w[8*i +: 8]);
        base = fetches;
        n = 0; first_valid = -1; last_hs = -1; done_c = -1; busy_cnt = 1;
        prev_stall = 1'b0; prev_idx = '0;
        idx_if.idx_ready = 1'b0;
        start = 1'b1;
        prog_addr = addr;
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0;
            prog_addr = 8'($urandom);
        end
        check("accept_busy", 64'(busy), 64'(1));
        check("reset_read_pulse", 64'(reset_read), 64'(1));
        check("read_addr", 64'(read_prog_addr), 64'(addr));
        c = 0;
        while (done_c < 0 && c < 2000) begin
            @(posedge clk); #1;
            c++;
            if (mid_start) begin
                if (c == 6) begin
                    start = 1'b1;
                    prog_addr = 8'd4;
                end else if (c == 7) begin
                    start = 1'b0;
                end
            end
            if (busy) begin
                busy_cnt++;
                check("addr_hold", 64'(read_prog_addr), 64'(addr));
            end
            if (abort && n == 2 && idx_if.idx_valid) begin
                #2 reset = 1'b1;
                #1;
                check("abort_valid", 64'(idx_if.idx_valid), 64'(0));
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_done", 64'(done), 64'(0));
                check("abort_idx", 64'(idx_if.idx_out), 64'(0));
                check("abort_reset_read", 64'(reset_read), 64'(0));
                #2 reset = 1'b0;
                return;
            end
            if (done) begin
                done_c = c;
            end else if (idx_if.idx_valid) begin
                if (first_valid < 0) first_valid = c;
                if (prev_stall) check("stall_hold", 64'(idx_if.idx_out), 64'(prev_idx));
                check("idx_last", 64'(idx_if.idx_last), 64'(n == total - 1));
                idx_if.idx_ready = next_ready(mode, c);
                if (idx_if.idx_ready) begin
                    if (n < total) check("tuple", 64'(idx_if.idx_out), 64'(exp_tuple(w, n)));
                    else check("tuple_overrun", 64'(n), 64'(total - 1));
                    if (idx_if.idx_last) last_hs = c;
                    n++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                end
                prev_idx = idx_if.idx_out;
            end else begin
                idx_if.idx_ready = 1'($urandom_range(0, 1));
            end
        end
        check("done_seen", 64'(done_c > 0), 64'(1));
        check("tuple_count", 64'(n), 64'(total));
        check("fetch_count", 64'(fetches - base), 64'(1));
        if (total > 0) begin
            check("first_valid", 64'(first_valid), 64'(4));
            check("done_after_last", 64'(done_c), 64'(last_hs + 1));
        end else begin
            check("empty_no_valid", 64'(first_valid), 64'(-1));
            check("empty_done", 64'(done_c), 64'(4));
            check("empty_busy", 64'(busy_cnt), 64'(5));
        end
        @(posedge clk); #1;
        check("done_width", 64'(done), 64'(0));
        if (!hold) begin
            check("idle_busy", 64'(busy), 64'(0));
        end else begin
            seen = 1'b0;
            for (int k = 0; k < 3 && !seen; k++) begin
                @(posedge clk); #1;
                if (reset_read) seen = 1'b1;
            end
            check("b2b_refetch", 64'(seen), 64'(1));
            check("b2b_addr", 64'(read_prog_addr), 64'(addr));
            start = 1'b0;
            idx_if.idx_ready = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 400 && !seen; k++) begin
                @(posedge clk); #1;
                if (done) seen = 1'b1;
            end
            check("b2b_done", 64'(seen), 64'(1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] w;
        int f;
        reset = 1'b1;
        start = 1'b0;
        prog_addr = 8'd0;
        idx_if.idx_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h01010101;
        mem[3]  = 32'h01010302;
        mem[4]  = 32'h01000302;
        mem[20] = 32'h010101FF;
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_reset_read", 64'(reset_read), 64'(0));
        check("rst_valid", 64'(idx_if.idx_valid), 64'(0));
        check("rst_last", 64'(idx_if.idx_last), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_addr", 64'(read_prog_addr), 64'(0));
        check("rst_idx", 64'(idx_if.idx_out), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        run_prog(8'd3, 0, 1'b0, 1'b0, 1'b0);
        run_prog(8'd3, 1, 1'b0, 1'b0, 1'b0);
        run_prog(8'd4, 0, 1'b0, 1'b0, 1'b0);
        run_prog(8'd3, 0, 1'b1, 1'b0, 1'b0);
        run_prog(8'd3, 0, 1'b0, 1'b1, 1'b0);
        run_prog(8'd3, 0, 1'b0, 1'b0, 1'b1);
        run_prog(8'd3, 0, 1'b0, 1'b0, 1'b0);
        run_prog(8'd20, 2, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            w = '0;
            for (int i = 0; i < 4; i++) begin
                f = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
                w[8*i +: 8] = 8'(f);
            end
            mem[8 + r] = w;
            run_prog(8'(8 + r), 2, 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
